// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
// - Default widths/depth used as parameter defaults by the top level.
// - Recovery FSM state encoding.
package branch_resolve_unit_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int IDX_W_DEF = 5;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // state      | meaning
  // ST_NORMAL  | accepting predictions, resolving the oldest in-flight branch
  // ST_RECOVER | one-cycle flush after a mispredict; fetch and resolve stalled
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } bru_state_e;

  // Packed entry layout is {pc, taken, target}.
  function automatic int entry_w(input int pc_w);
    return 2 * pc_w + 1;
  endfunction

endpackage

// File: rtl/branch_tag_fifo.sv
// In-order queue of in-flight predicted branches.
// Ports:
//   clk, arst       clock, async active-high reset
//   push, pop       enqueue wr_data / drop the head entry
//   clear           empty the queue (wins over push)
//   wr_data         entry to enqueue
//   rd_data         current head entry (meaningful only when count != 0)
//   count           current occupancy
module branch_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // DEPTH is a power of two, so natural pointer overflow wraps correctly.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: tracks predicted branches in order,
// compares each against its resolved outcome, drives the BHT update and
// raises flush/redirect on a mispredict.
// Ports:
//   clk, arst                 clock, async active-high reset
//   pred_*                    prediction from fetch (pred_ready is combinational)
//   res_*                     resolution of the oldest in-flight branch
//   upd_en/addr/taken         registered BHT write, one cycle after res_valid
//   flush, redirect_pc        kill younger work and refetch
//   inflight                  queue occupancy
//   branch_cnt, mispred_cnt   saturating statistics
//   underflow_err             sticky: resolve seen with nothing in flight
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  input  logic [PC_W-1:0]            pred_target,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [PC_W-1:0]            res_target,
  output logic                       upd_en,
  output logic [IDX_W-1:0]           upd_addr,
  output logic                       upd_taken,
  output logic                       flush,
  output logic [PC_W-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           mispred_cnt,
  output logic                       underflow_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = entry_w(PC_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  bru_state_e r_state;
  bru_state_e w_state_nxt;

  logic [EW-1:0]    w_head;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_taken;
  logic [PC_W-1:0]  w_head_tgt;
  logic             w_resolve;
  logic             w_mispred;
  logic             w_underflow;
  logic             w_push;

  logic             r_upd_en;
  logic [IDX_W-1:0] r_upd_addr;
  logic             r_upd_taken;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic             r_underflow_err;

  branch_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .push    (w_push),
    .pop     (w_resolve),
    .clear   (w_mispred),
    .wr_data ({pred_pc, pred_taken, pred_target}),
    .rd_data (w_head),
    .count   (inflight)
  );

  assign w_head_pc    = w_head[EW-1 -: PC_W];
  assign w_head_taken = w_head[PC_W];
  assign w_head_tgt   = w_head[PC_W-1:0];

  // Ready deliberately ignores a same-cycle pop to keep the fetch path short.
  assign pred_ready = (r_state == ST_NORMAL) && (inflight < DEPTH_C);

  // A push racing a mispredict is wrong-path and gets dropped with the rest.
  assign w_push = pred_valid && pred_ready && !w_mispred;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_NORMAL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_resolve   = 1'b0;
    w_mispred   = 1'b0;
    w_underflow = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        w_resolve   = res_valid && (inflight != '0);
        w_underflow = res_valid && (inflight == '0);
        w_mispred   = w_resolve &&
                      ((res_taken != w_head_taken) ||
                       (res_taken && (res_target != w_head_tgt)));
        if (w_mispred) w_state_nxt = ST_RECOVER;
      end
      ST_RECOVER: w_state_nxt = ST_NORMAL;
      default:    w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_upd_en        <= 1'b0;
      r_upd_addr      <= '0;
      r_upd_taken     <= 1'b0;
      r_redirect_pc   <= '0;
      r_branch_cnt    <= '0;
      r_mispred_cnt   <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      r_upd_en <= w_resolve;
      if (w_resolve) begin
        r_upd_addr  <= w_head_pc[IDX_W+1:2];
        r_upd_taken <= res_taken;
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mispred) begin
        r_redirect_pc <= res_taken ? res_target : (w_head_pc + PC_W'(4));
        if (r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
      if (w_underflow) r_underflow_err <= 1'b1;
    end
  end

  assign upd_en        = r_upd_en;
  assign upd_addr      = r_upd_addr;
  assign upd_taken     = r_upd_taken;
  assign flush         = (r_state == ST_RECOVER);
  assign redirect_pc   = r_redirect_pc;
  assign branch_cnt    = r_branch_cnt;
  assign mispred_cnt   = r_mispred_cnt;
  assign underflow_err = r_underflow_err;

endmodule
